// File: rtl/mx_scale_accum.sv
// Streaming MX shared-scale generator: tracks the max FP32 exponent of a block and emits an E8M0 scale.
// Optional macro MX_SCALE_NAN_EN: Inf/NaN elements force the scale to 8'hFF instead of being skipped.
module mx_scale_accum #(
    parameter int BLOCK_SIZE = 32,
    parameter int CNT_W      = 9,
    parameter int EXP_OFFSET = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_scale,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   counter_r, counter_nxt_s;
    logic [7:0]         max_exp_r, max_nxt_s;
    logic               special_r, special_nxt_s;
    logic [7:0]         scale_r, scale_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               zero_r, zero_nxt_s;
    logic [7:0]         exp_s;
    logic               is_inf_s;
    logic               unused_s;

    function automatic logic [7:0] scale_of(input logic [7:0] m, input logic sp);
        logic [7:0] s;
        if (sp) begin
            s = 8'hFF;
        end else if (m <= 8'(EXP_OFFSET)) begin
            s = 8'h00;
        end else begin
            s = m - 8'(EXP_OFFSET);
        end
        return s;
    endfunction

    assign exp_s    = in_data[30:23];
    assign is_inf_s = (exp_s == 8'hFF);
    // Sign and mantissa never influence the shared scale.
    assign unused_s = ^{in_data[31], in_data[22:0]};

    // Next-state, accumulator update and close-of-block scale computation.
    always_comb begin
        state_nxt_s   = state_r;
        counter_nxt_s = counter_r;
        max_nxt_s     = max_exp_r;
        special_nxt_s = special_r;
        scale_nxt_s   = scale_r;
        count_nxt_s   = count_r;
        zero_nxt_s    = zero_r;
        case (state_r)
            ACCUM: begin
                if (in_valid) begin
                    counter_nxt_s = counter_r + CNT_W'(1);
`ifdef MX_SCALE_NAN_EN
                    if (is_inf_s) begin
                        special_nxt_s = 1'b1;
                    end else if (exp_s > max_exp_r) begin
                        max_nxt_s = exp_s;
                    end else begin
                        max_nxt_s = max_exp_r;
                    end
`else
                    if (!is_inf_s && (exp_s > max_exp_r)) begin
                        max_nxt_s = exp_s;
                    end else begin
                        max_nxt_s = max_exp_r;
                    end
`endif
                    if (in_last || (counter_r == CNT_W'(BLOCK_SIZE - 1))) begin
                        state_nxt_s = HOLD;
                        scale_nxt_s = scale_of(max_nxt_s, special_nxt_s);
                        count_nxt_s = counter_r + CNT_W'(1);
                        zero_nxt_s  = (max_nxt_s == 8'h00) && !special_nxt_s;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s   = ACCUM;
                    counter_nxt_s = '0;
                    max_nxt_s     = 8'h00;
                    special_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ACCUM;
            counter_r <= '0;
            max_exp_r <= 8'h00;
            special_r <= 1'b0;
            scale_r   <= 8'h00;
            count_r   <= '0;
            zero_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            counter_r <= counter_nxt_s;
            max_exp_r <= max_nxt_s;
            special_r <= special_nxt_s;
            scale_r   <= scale_nxt_s;
            count_r   <= count_nxt_s;
            zero_r    <= zero_nxt_s;
        end
    end

    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == HOLD);
    assign out_scale = scale_r;
    assign out_count = count_r;
    assign out_zero  = zero_r;

endmodule

// File: tb/tb_mx_scale_accum.sv
// Scoreboard bench for mx_scale_accum: directed blocks push expected scales, a monitor checks each handshake.
module tb_mx_scale_accum;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b1;
    logic [31:0]      in_data = 32'h0;
    logic             in_ready, out_valid, out_zero;
    logic [7:0]       out_scale;
    logic [CNT_W-1:0] out_count;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    mx_scale_accum dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_scale(out_scale), .out_count(out_count), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] fp(input logic s, input logic [7:0] e, input logic [22:0] m);
        return {s, e, m};
    endfunction

    task automatic expect_out(input logic [7:0] sc, input logic [8:0] cnt, input logic z);
        exp_q.push_back({sc, cnt, z});
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (!(in_ready && !out_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("idle_reached", {31'h0, in_ready && !out_valid}, 32'h1);
    endtask

    // Scoreboard monitor: compare on each accepted output.
    always @(negedge clk) begin : mon
        logic [17:0] item;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=scale_%0h required=no_output", out_scale);
            end else begin
                item = exp_q.pop_front();
                chk("out_scale", {24'h0, out_scale}, {24'h0, item[17:10]});
                chk("out_count", {23'h0, out_count}, {23'h0, item[9:1]});
                chk("out_zero", {31'h0, out_zero}, {31'h0, item[0]});
            end
        end
    end

    initial begin
        logic [7:0] t2 [5];
        t2 = '{8'h10, 8'h20, 8'h85, 8'h30, 8'h40};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_scale", {24'h0, out_scale}, 32'h0);

        // Full block, ascending exponents 0x70..0x8F, alternating sign.
        for (int i = 0; i < 32; i++) begin
            if (i == 31) expect_out(8'h88, 9'd32, 1'b0);
            send(fp(i[0], 8'h70 + 8'(i), 23'h1234), 1'b0);
            if (i == 30) chk("t1_valid_before_close", {31'h0, out_valid}, 32'h0);
        end
        chk("t1_valid_after_close", {31'h0, out_valid}, 32'h1);
        chk("t1_ready_after_close", {31'h0, in_ready}, 32'h0);

        // Early close via in_last.
        expect_out(8'h7E, 9'd5, 1'b0);
        for (int i = 0; i < 5; i++) send(fp(1'b0, t2[i], 23'h0), i == 4);

        // All zero / subnormal block, then clamp with max exponent 0x07.
        expect_out(8'h00, 9'd32, 1'b1);
        for (int i = 0; i < 32; i++) send(fp(i[0], 8'h00, 23'(i)), 1'b0);
        expect_out(8'h00, 9'd3, 1'b0);
        send(fp(1'b0, 8'h01, 23'h0), 1'b0);
        send(fp(1'b1, 8'h07, 23'h0), 1'b0);
        send(fp(1'b0, 8'h00, 23'h0), 1'b1);

        // NaN as element 10, others exponent 0x80.
`ifdef MX_SCALE_NAN_EN
        expect_out(8'hFF, 9'd32, 1'b0);
`else
        expect_out(8'h79, 9'd32, 1'b0);
`endif
        for (int i = 0; i < 32; i++) send((i == 9) ? 32'h7FC00000 : fp(1'b0, 8'h80, 23'h0), 1'b0);

        // Backpressure with in_valid/in_last held during HOLD.
        wait_idle();
        @(posedge clk);
        #1 out_ready = 1'b0;
        expect_out(8'h83, 9'd4, 1'b0);
        send(fp(1'b0, 8'h81, 23'h0), 1'b0);
        send(fp(1'b0, 8'h8A, 23'h0), 1'b0);
        send(fp(1'b0, 8'h82, 23'h0), 1'b0);
        send(fp(1'b0, 8'h83, 23'h0), 1'b1);
        in_valid = 1'b1;
        in_data  = fp(1'b0, 8'hFE, 23'h0);
        in_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_scale_stable", {24'h0, out_scale}, 32'h83);
            chk("bp_count_stable", {23'h0, out_count}, 32'h4);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {31'h0, out_valid}, 32'h0);
        chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
        expect_out(8'h89, 9'd2, 1'b0);
        send(fp(1'b0, 8'h90, 23'h0), 1'b0);
        send(fp(1'b1, 8'h10, 23'h0), 1'b1);

        // Reset mid-block discards the partial block.
        wait_idle();
        for (int i = 0; i < 12; i++) send(fp(1'b0, 8'hF0, 23'h0), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_out_scale", {24'h0, out_scale}, 32'h0);
        chk("mid_rst_out_count", {23'h0, out_count}, 32'h0);
        chk("mid_rst_out_zero", {31'h0, out_zero}, 32'h0);
        expect_out(8'h7A, 9'd32, 1'b0);
        for (int i = 0; i < 32; i++) send(fp(1'b0, 8'h81, 23'h0), 1'b0);

        wait_idle();
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/mx_scale_accum.md
Name: mx_scale_accum

Overview:
- Streaming shared-scale generator for MX quantisation of FP32 data.
- Accepts one FP32 element per cycle and tracks the block's maximum biased exponent over up to BLOCK_SIZE elements.
- Emits one E8M0 shared scale per block with a valid/ready handshake.
- Sits ahead of the per-element FP32-to-E4M3/E5M2/E2M1 converters; EXP_OFFSET sets the target element format.

Parameters:
- BLOCK_SIZE, 32, elements per MX block (2..256).
- CNT_W, 9, width of the element counter and out_count; must satisfy 2^CNT_W > BLOCK_SIZE.
- EXP_OFFSET, 7, value subtracted from the block max biased exponent to form the scale (7 for E4M3 in this codebase).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  element valid.
- in_ready  output  1  block can accept an element.
- in_data  input  32  FP32 element (sign, 8-bit exponent, 23-bit mantissa).
- in_last  input  1  element closes the block early.
- out_valid  output  1  scale valid.
- out_ready  input  1  downstream accepts the scale.
- out_scale  output  8  E8M0 shared scale.
- out_count  output  CNT_W  number of elements in the block.
- out_zero  output  1  all elements were ±0 or subnormal (exponent field 0).

Behaviour:
- Reset values (applied when rst_n=0 at a clk edge):
  - State is ACCUM; counter=0, max_exp=0, special=0.
  - in_ready=1, out_valid=0, out_scale=0, out_count=0, out_zero=0.
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM, element accepted (in_valid & in_ready):
  - E = in_data[30:23].
  - If E==8'hFF: set special. Otherwise max_exp <= max(max_exp, E).
  - counter increments.
- Block closes on the accepting edge when counter==BLOCK_SIZE-1 or in_last=1, whichever comes first.
  - The closing element's exponent is included in the result.
  - out_count = counter+1.
- Scale computation (registered on the closing edge):
  - special=1: scale 8'hFF.
  - Else if M <= EXP_OFFSET: scale 8'h00.
  - Else: scale M-EXP_OFFSET, where M is the final max exponent. 8-bit unsigned; no wrap can occur.
  - Example: M=8'hFE with EXP_OFFSET=7 gives 8'hF7.
- out_zero = 1 iff M==0 and special=0.
- On the closing edge, state goes to HOLD. out_valid asserts the following cycle, giving 1-cycle latency from the last element.
- HOLD:
  - Outputs stay stable until out_ready=1.
  - On that edge: out_valid<=0, accumulators cleared, return to ACCUM. in_ready=1 the next cycle; no bypass.
- in_valid while in_ready=0: ignored; data is not consumed.
- in_last on a non-accepted cycle: ignored.
- Sign bit is ignored throughout.
- Reset mid-block or during HOLD: discards the partial block and any pending scale. No output is produced for it.
- Throughput: one block per (elements + 1 + out_ready wait) cycles.

Optional Feature:
- Macro MX_SCALE_NAN_EN.
- Defined: any element with E==8'hFF (Inf/NaN) forces out_scale=8'hFF, as specified above.
- Undefined: elements with E==8'hFF are excluded from the max; special is never set. Scale is computed from the finite elements only, and such elements do not clear out_zero.
- In both builds the counter counts every element.

Test Plan:
- Full block, default params, 32 elements with exponents 8'h70..8'h8F ascending, out_ready=1 -> out_scale=8'h88, out_count=32, out_zero=0; out_valid one cycle after 32nd accept.
- Early close: 5 elements, exponent 8'h85 on the 3rd, in_last on the 5th -> out_scale=8'h7E, out_count=5; next block starts fresh (max_exp=0).
- Clamp and zero: 32 elements, all 32'h00000000 -> out_scale=8'h00, out_zero=1. A block with max exponent 8'h07 -> out_scale=8'h00, out_zero=0.
- Special, NaN build: element 10 = 32'h7FC00000, others exponent 8'h80:
  - MX_SCALE_NAN_EN defined -> out_scale=8'hFF.
  - Macro undefined -> out_scale=8'h79.
- Backpressure: hold out_ready=0 for 6 cycles after close with in_valid=1 -> in_ready=0, out_scale/out_count stable, no element consumed. Release -> out_valid drops, next block accepted the following cycle.
- Reset mid-block: 12 elements accepted, rst_n=0 for one cycle, then 32 elements of exponent 8'h81 -> out_scale=8'h7A, out_count=32, no earlier output.
